// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes and the RX alignment FSM encoding.
// Used by both the encoder and decoder sides of the link.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } tmds_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one 10-bit TMDS character into de / control bits / pixel byte.
// de=0 marks a control token; any non-token word is treated as a video character.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       de,
  output logic [1:0] c,
  output logic [7:0] data
);

  logic [7:0] q_inv;
  logic [7:0] q_x;

  always_comb begin
    de    = 1'b0;
    c     = 2'b00;
    data  = 8'h00;
    q_inv = word[9] ? ~word[7:0] : word[7:0];
    // Adjacent-bit XOR undoes the encoder's running XOR/XNOR chain; bit 0 passes through.
    q_x   = q_inv ^ {q_inv[6:0], 1'b0};
    case (word)
      TOK_C00: c = 2'b00;
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: begin
        de   = 1'b1;
        data = word[8] ? q_x : {~q_x[7:1], q_x[0]};
      end
    endcase
  end

endmodule

// File: rtl/tmds_rx_decoder.sv
// Single-channel TMDS receive decoder: word-alignment search via bitslip, lock tracking
// on control tokens, and a two-stage register/decode pipeline for the character stream.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       I_rgb_clk,
  input  logic       I_rst_n,
  input  logic [9:0] I_tmds_word,
  output logic       O_bitslip,
  output logic       O_aligned,
  output logic       O_de,
  output logic [1:0] O_c,
  output logic [7:0] O_data
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  function automatic int sat_inc(input int v, input int vmax);
    return (v >= vmax) ? vmax : v + 1;
  endfunction

  tmds_state_e       state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [SRCH_W-1:0] srch_cnt, srch_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LOSS_W-1:0] loss_cnt, loss_nxt;

  logic [9:0] word_p1;
  logic       dec_de;
  logic [1:0] dec_c;
  logic [7:0] dec_data;
  logic       is_tok;

  // Stage 1: input register; the alignment FSM works on this word
  always_ff @(posedge I_rgb_clk) begin
    if (!I_rst_n) word_p1 <= '0;
    else          word_p1 <= I_tmds_word;
  end

  tmds_word_decode u_dec (
    .word (word_p1),
    .de   (dec_de),
    .c    (dec_c),
    .data (dec_data)
  );

  assign is_tok = ~dec_de;

  always_ff @(posedge I_rgb_clk) begin
    if (!I_rst_n) begin
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      srch_cnt <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      srch_cnt <= srch_nxt;
      wait_cnt <= wait_nxt;
      loss_cnt <= loss_nxt;
    end
  end

  // Each counter is only live in its own state and falls back to zero elsewhere.
  always_comb begin
    state_nxt = state;
    run_nxt   = '0;
    srch_nxt  = '0;
    wait_nxt  = '0;
    loss_nxt  = '0;
    case (state)
      ST_SEARCH: begin
        if (is_tok) begin
          run_nxt   = RUN_W'(1);
          state_nxt = (TOKEN_RUN <= 1) ? ST_LOCKED : ST_CHECK;
        end else if (int'(srch_cnt) + 1 >= SEARCH_TIMEOUT) begin
          state_nxt = ST_SLIP;
        end else begin
          srch_nxt = SRCH_W'(sat_inc(int'(srch_cnt), SEARCH_TIMEOUT));
        end
      end
      ST_CHECK: begin
        if (!is_tok)                            state_nxt = ST_SEARCH;
        else if (int'(run_cnt) + 1 >= TOKEN_RUN) state_nxt = ST_LOCKED;
        else run_nxt = RUN_W'(sat_inc(int'(run_cnt), TOKEN_RUN));
      end
      ST_SLIP: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (int'(wait_cnt) + 1 >= SLIP_WAIT) state_nxt = ST_SEARCH;
        else wait_nxt = WAIT_W'(sat_inc(int'(wait_cnt), SLIP_WAIT));
      end
      ST_LOCKED: begin
        if (is_tok)                                   loss_nxt  = '0;
        else if (int'(loss_cnt) + 1 >= LOSS_TIMEOUT)  state_nxt = ST_SEARCH;
        else loss_nxt = LOSS_W'(sat_inc(int'(loss_cnt), LOSS_TIMEOUT));
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  assign O_aligned = (state == ST_LOCKED);
  assign O_bitslip = (state == ST_SLIP);

  // Stage 2: output register, gated by the state being entered so data and O_aligned agree
  always_ff @(posedge I_rgb_clk) begin
    if (!I_rst_n) begin
      O_de   <= 1'b0;
      O_c    <= 2'b00;
      O_data <= 8'h00;
    end else if (state_nxt == ST_LOCKED) begin
      O_de   <= dec_de;
      O_data <= dec_de ? dec_data : 8'h00;
      if (!dec_de) O_c <= dec_c;
    end else begin
      O_de   <= 1'b0;
      O_c    <= 2'b00;
      O_data <= 8'h00;
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Randomized bench for tmds_rx_decoder against a cycle-level behavioural model of the
// alignment rules, with directed checks on lock timing, loss, bitslip search and reset.
module tb_tmds_rx_decoder;

  localparam int TOKEN_RUN      = 8;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int SLIP_WAIT      = 16;
  localparam int LOSS_TIMEOUT   = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] word = '0;
  logic       bitslip, aligned, de;
  logic [1:0] c;
  logic [7:0] data;

  always #5 clk = ~clk;

  tmds_rx_decoder #(
    .TOKEN_RUN      (TOKEN_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .I_rgb_clk   (clk),
    .I_rst_n     (rst_n),
    .I_tmds_word (word),
    .O_bitslip   (bitslip),
    .O_aligned   (aligned),
    .O_de        (de),
    .O_c         (c),
    .O_data      (data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model state: everything the receiver should be doing, in plain integers.
  logic [9:0] m_w1 = '0;
  logic       m_locked = 1'b0;
  int         m_run = 0, m_idle = 0, m_settle = 0;
  logic [1:0] m_c = 2'b00;
  logic       exp_de = 1'b0;
  logic [7:0] exp_data = 8'h00;

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] tok_word(input int k);
    case (k)
      0:       return 10'h354;
      1:       return 10'h0AB;
      2:       return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Find the byte whose TMDS encoding (XOR/XNOR chain, optional inversion) yields w.
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] qp, qm, dv;
    qp = w[9] ? ~w[7:0] : w[7:0];
    for (int d = 0; d < 256; d++) begin
      dv    = 8'(d);
      qm[0] = dv[0];
      for (int i = 1; i < 8; i++) qm[i] = w[8] ? (qm[i-1] ^ dv[i]) : ~(qm[i-1] ^ dv[i]);
      if (qm == qp) return dv;
    end
    return 8'h00;
  endfunction

  function automatic logic [9:0] rand_video();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (tok_code(w) >= 0);
    return w;
  endfunction

  function automatic logic [9:0] rot_word(input logic [9:0] w, input int off);
    logic [19:0] dbl;
    dbl = {w, w};
    return dbl[off +: 10];
  endfunction

  task automatic model_edge(input logic [9:0] w_in, input logic rstn);
    int tc;
    if (!rstn) begin
      m_w1 = '0; m_locked = 1'b0; m_run = 0; m_idle = 0; m_settle = 0;
      m_c = 2'b00; exp_de = 1'b0; exp_data = 8'h00;
      return;
    end
    tc = tok_code(m_w1);
    if (m_settle > 0) begin
      m_settle--;
    end else if (m_locked) begin
      if (tc >= 0) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == LOSS_TIMEOUT) begin m_locked = 1'b0; m_idle = 0; end
      end
    end else if (tc >= 0) begin
      m_run++; m_idle = 0;
      if (m_run == TOKEN_RUN) begin m_locked = 1'b1; m_run = 0; end
    end else if (m_run > 0) begin
      m_run = 0; m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == SEARCH_TIMEOUT) begin m_settle = SLIP_WAIT + 1; m_idle = 0; end
    end
    if (m_locked) begin
      if (tc >= 0) begin exp_de = 1'b0; m_c = tc[1:0]; exp_data = 8'h00; end
      else begin exp_de = 1'b1; exp_data = ref_decode(m_w1); end
    end else begin
      exp_de = 1'b0; m_c = 2'b00; exp_data = 8'h00;
    end
    m_w1 = w_in;
  endtask

  task automatic step(input logic [9:0] w, input logic rstn);
    @(negedge clk);
    word  = w;
    rst_n = rstn;
    @(posedge clk);
    model_edge(w, rstn);
    #1;
    cyc++;
    chk("outs", {19'd0, bitslip, aligned, de, c, data},
        {19'd0, (m_settle == SLIP_WAIT + 1), m_locked, exp_de, m_c, exp_data});
    if (bitslip) n_pulse++;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lock_at, fall_at, p0, off, last_pulse, got_first, got_lock;

    for (int i = 0; i < 3; i++) step(rand_video(), 1'b0);
    chk("rst_zero", {19'd0, bitslip, aligned, de, c, data}, 32'd0);

    // Aligned blanking stream: lock one cycle after the 8th token is registered.
    p0 = n_pulse;
    lock_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(10'h354, 1'b1);
      if (aligned && lock_at < 0) lock_at = i;
    end
    chk("lock_cyc", lock_at, 8);
    for (int i = 0; i < 30; i++) step(rand_video(), 1'b1);
    chk("no_slip", n_pulse - p0, 0);
    chk("c_hold", c, 2'b00);

    // Boundary characters, two-cycle latency.
    step(10'h100, 1'b1);
    step(10'h200, 1'b1);
    chk("d100", {de, data}, {1'b1, 8'h00});
    step(rand_video(), 1'b1);
    chk("d200", {de, data}, {1'b1, 8'hFF});

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) step(tok_word(int'($urandom_range(0, 3))), 1'b1);
      else step(rand_video(), 1'b1);
    end

    // Reset while locked, then an aborted token run followed by a clean one.
    step(rand_video(), 1'b0);
    chk("rst_lock", {19'd0, bitslip, aligned, de, c, data}, 32'd0);
    for (int i = 0; i < 5; i++) step(10'h154, 1'b1);
    step(rand_video(), 1'b1);
    step(rand_video(), 1'b1);
    chk("abort_unlocked", aligned, 1'b0);
    for (int i = 0; i < 8; i++) step(10'h2AB, 1'b1);
    chk("abort_no_early", aligned, 1'b0);
    step(10'h2AB, 1'b1);
    chk("relock", aligned, 1'b1);
    chk("relock_c", c, 2'b11);

    // Loss of lock after LOSS_TIMEOUT token-free cycles.
    fall_at = -1;
    for (int i = 0; i < LOSS_TIMEOUT + 4; i++) begin
      step(rand_video(), 1'b1);
      if (!aligned && fall_at < 0) fall_at = i;
    end
    chk("loss_cyc", fall_at, LOSS_TIMEOUT);
    chk("loss_de", de, 1'b0);

    // Misaligned blanking stream; the deserializer model rotates one bit per pulse.
    off = 3;
    p0 = n_pulse;
    got_first = 0;
    for (int i = 0; i < 2000 && !got_first; i++) begin
      step(rot_word(10'h0AB, off), 1'b1);
      if (bitslip) begin off = (off + 1) % 10; got_first = 1; end
    end
    chk("first_slip", got_first, 1);
    for (int i = 0; i < 5; i++) step(rot_word(10'h0AB, off), 1'b1);
    step(rot_word(10'h0AB, off), 1'b0);
    chk("rst_wait", {19'd0, bitslip, aligned, de, c, data}, 32'd0);

    got_lock = 0;
    last_pulse = -1;
    for (int i = 0; i < 15000 && !got_lock; i++) begin
      step(rot_word(10'h0AB, off), 1'b1);
      if (bitslip) begin
        if (last_pulse >= 0) chk("slip_gap", (cyc - last_pulse) >= SLIP_WAIT + 1, 1);
        last_pulse = cyc;
        off = (off + 1) % 10;
      end
      if (aligned) got_lock = 1;
    end
    chk("slip_lock", got_lock, 1);
    chk("slip_count", (n_pulse - p0) <= 9, 1);
    step(rot_word(10'h0AB, off), 1'b1);
    step(rot_word(10'h0AB, off), 1'b1);
    chk("blank_c", c, 2'b01);
    chk("blank_de", de, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
